// File: rtl/pulse_stretcher_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : pulse_stretcher_pkg                                        |
// | Description : Shared definitions for the pulse stretcher: 2-bit state    |
// |               encodings and the counter-width helper function.           |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package pulse_stretcher_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        HIGH = 2'b01,
        GAP  = 2'b10
    } ps_state_e;

    // Width needed to hold any value 0..max(hold_high, hold_low).
    function automatic int ps_cnt_width(input int hold_high, input int hold_low);
        int w_max;
        w_max = (hold_high > hold_low) ? hold_high : hold_low;
        return (w_max < 1) ? 1 : $clog2(w_max + 1);
    endfunction

endpackage : pulse_stretcher_pkg
`default_nettype wire

// File: rtl/edge_detect_rise.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : edge_detect_rise                                           |
// | Description : Rising-edge detector. Registers the previous value of the  |
// |               input and flags a cycle where the input is high but was    |
// |               low on the previous clock.                                 |
// | Ports       : i_clk   - clock, rising edge                               |
// |               i_rst_n - asynchronous active-low reset                    |
// |               i_sig   - synchronous input level                          |
// |               o_rise  - combinational rising-edge flag                   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module edge_detect_rise (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_sig,
    output logic o_rise
);

    logic r_prev;

    // Previous value clears in reset, so a level held high through reset
    // release is seen as a fresh edge on the first clock afterwards.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= i_sig;
        end
    end

    assign o_rise = i_sig & ~r_prev;

endmodule : edge_detect_rise
`default_nettype wire

// File: rtl/pulse_stretcher.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : pulse_stretcher                                            |
// | Description : Converts short or chattering trigger events into clean    |
// |               output pulses with a guaranteed high time (HOLD_HIGH) and  |
// |               a guaranteed low gap (HOLD_LOW). One event arriving during |
// |               a pulse or gap is held in a pending slot; a further event  |
// |               while the slot is full is reported on o_dropped.           |
// | Ports       : i_clk      - clock, rising edge                            |
// |               i_rst_n    - asynchronous active-low reset                 |
// |               i_trigger  - trigger level, each rising edge is one event  |
// |               o_out      - stretched pulse output (registered)           |
// |               o_busy     - high whenever the FSM is not idle             |
// |               o_dropped  - one-cycle flag: event lost, slot was full     |
// | Options     : PULSE_STRETCHER_RETRIGGER_EN - when defined, an edge       |
// |               during HIGH restarts the high timer instead of using the   |
// |               pending slot. Edges during GAP still use the slot.         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module pulse_stretcher
    import pulse_stretcher_pkg::*;
#(
    parameter int HOLD_HIGH = 4,
    parameter int HOLD_LOW  = 2,
    parameter int CNT_WIDTH = ps_cnt_width(HOLD_HIGH, HOLD_LOW)
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_trigger,
    output logic o_out,
    output logic o_busy,
    output logic o_dropped
);

    localparam logic [CNT_WIDTH-1:0] c_cnt_hi   = CNT_WIDTH'(HOLD_HIGH - 1);
    localparam logic [CNT_WIDTH-1:0] c_cnt_lo   = CNT_WIDTH'(HOLD_LOW - 1);
    localparam logic [CNT_WIDTH-1:0] c_cnt_one  = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] c_cnt_zero = '0;

    ps_state_e              r_state;
    logic [CNT_WIDTH-1:0]   r_cnt;
    logic                   r_pending;
    logic                   r_out;
    logic                   r_busy;
    logic                   r_dropped;
    logic                   w_edge;

    edge_detect_rise u_edge (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_sig   (i_trigger),
        .o_rise  (w_edge)
    );

    // Counter is loaded only on entry to HIGH/GAP and decremented only while
    // non-zero, so it can never wrap.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= IDLE;
            r_cnt     <= c_cnt_zero;
            r_pending <= 1'b0;
            r_out     <= 1'b0;
            r_busy    <= 1'b0;
            r_dropped <= 1'b0;
        end else begin
            r_dropped <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_edge) begin
                        r_state <= HIGH;
                        r_cnt   <= c_cnt_hi;
                        r_out   <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end

                HIGH: begin
`ifdef PULSE_STRETCHER_RETRIGGER_EN
                    // A new event restarts the high timer, even on the cycle
                    // the timer would otherwise have expired.
                    if (w_edge) begin
                        r_cnt <= c_cnt_hi;
                    end else if (r_cnt != c_cnt_zero) begin
                        r_cnt <= r_cnt - c_cnt_one;
                    end else begin
                        r_state <= GAP;
                        r_cnt   <= c_cnt_lo;
                        r_out   <= 1'b0;
                    end
`else
                    if (r_cnt != c_cnt_zero) begin
                        r_cnt <= r_cnt - c_cnt_one;
                    end else begin
                        r_state <= GAP;
                        r_cnt   <= c_cnt_lo;
                        r_out   <= 1'b0;
                    end
                    if (w_edge) begin
                        if (!r_pending) begin
                            r_pending <= 1'b1;
                        end else begin
                            r_dropped <= 1'b1;
                        end
                    end
`endif
                end

                GAP: begin
                    if (r_cnt != c_cnt_zero) begin
                        r_cnt <= r_cnt - c_cnt_one;
                        if (w_edge) begin
                            if (!r_pending) begin
                                r_pending <= 1'b1;
                            end else begin
                                r_dropped <= 1'b1;
                            end
                        end
                    end else if (r_pending) begin
                        // Pending event is consumed; a coincident new edge
                        // immediately refills the slot without a drop.
                        r_state   <= HIGH;
                        r_cnt     <= c_cnt_hi;
                        r_out     <= 1'b1;
                        r_pending <= w_edge;
                    end else if (w_edge) begin
                        // Gap already satisfied: behave as an IDLE edge with
                        // no extra gap cycle.
                        r_state <= HIGH;
                        r_cnt   <= c_cnt_hi;
                        r_out   <= 1'b1;
                    end else begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end

                default: begin
                    r_state   <= IDLE;
                    r_cnt     <= c_cnt_zero;
                    r_pending <= 1'b0;
                    r_out     <= 1'b0;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

    assign o_out     = r_out;
    assign o_busy    = r_busy;
    assign o_dropped = r_dropped;

endmodule : pulse_stretcher
`default_nettype wire

// File: tb/tb_pulse_stretcher.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_pulse_stretcher                                         |
// | Description : Directed self-checking bench for pulse_stretcher with      |
// |               HOLD_HIGH=4, HOLD_LOW=3. Trigger patterns are bit vectors  |
// |               (bit i = level before clock i); outputs are captured 1 ns  |
// |               after each clock and compared against hand-derived masks.  |
// |               Expectations follow PULSE_STRETCHER_RETRIGGER_EN.          |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_pulse_stretcher;

    logic i_clk     = 1'b0;
    logic i_rst_n   = 1'b0;
    logic i_trigger = 1'b0;
    logic o_out;
    logic o_busy;
    logic o_dropped;

    int total = 0;
    int bad   = 0;

    logic [63:0] r_ov;
    logic [63:0] r_bv;
    logic [63:0] r_dv;

    pulse_stretcher #(
        .HOLD_HIGH (4),
        .HOLD_LOW  (3)
    ) dut (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_trigger (i_trigger),
        .o_out     (o_out),
        .o_busy    (o_busy),
        .o_dropped (o_dropped)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic apply(input logic [63:0] pat, input int n,
                         output logic [63:0] ov, output logic [63:0] bv,
                         output logic [63:0] dv);
        ov = '0;
        bv = '0;
        dv = '0;
        for (int i = 0; i < n; i++) begin
            i_trigger = pat[i];
            @(posedge i_clk);
            #1;
            ov[i] = o_out;
            bv[i] = o_busy;
            dv[i] = o_dropped;
        end
    endtask

    task automatic run_case(input string tag, input logic [63:0] pat,
                            input logic [63:0] exp_o, input logic [63:0] exp_b,
                            input logic [63:0] exp_d);
        logic [63:0] ov;
        logic [63:0] bv;
        logic [63:0] dv;
        apply(pat, 24, ov, bv, dv);
        check({tag, "_out"},  ov, exp_o);
        check({tag, "_busy"}, bv, exp_b);
        check({tag, "_drop"}, dv, exp_d);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state, during and after release
        #2;
        check("reset_hold", {61'd0, o_out, o_busy, o_dropped}, 64'd0);
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;
        check("reset_idle", {61'd0, o_out, o_busy, o_dropped}, 64'd0);

        // Single 1-cycle trigger: high 4, gap 3
        run_case("single", 64'h1, 64'hF, 64'h7F, 64'h0);

        // Trigger held 20 cycles: one pulse only
        run_case("held", 64'hFFFFF, 64'hF, 64'h7F, 64'h0);

`ifdef PULSE_STRETCHER_RETRIGGER_EN
        run_case("second_at2",   64'h5,  64'h3F,   64'h1FF,    64'h0);
        run_case("second_at3",   64'h9,  64'h7F,   64'h3FF,    64'h0);
        run_case("three_edges",  64'h15, 64'hFF,   64'h7FF,    64'h0);
        run_case("gap_pend_hit", 64'h85, 64'h1E3F, 64'hFFFF,   64'h0);
`else
        run_case("second_at2",   64'h5,  64'h78F,   64'h3FFF,   64'h0);
        run_case("second_at3",   64'h9,  64'h78F,   64'h3FFF,   64'h0);
        run_case("three_edges",  64'h15, 64'h78F,   64'h3FFF,   64'h10);
        run_case("gap_pend_hit", 64'h85, 64'h3C78F, 64'h1FFFFF, 64'h0);
`endif

        // Edge exactly as an empty gap expires: straight back to HIGH
        run_case("gap_expire_edge", 64'h81, 64'h78F, 64'h3FFF, 64'h0);

        // Reset during GAP with an event pending: everything cleared at once
        apply(64'h5, 5, r_ov, r_bv, r_dv);
        check("pre_rst_gap_busy", {63'd0, o_busy}, 64'd1);
        #2;
        i_rst_n = 1'b0;
        #1;
        check("rst_gap_async", {61'd0, o_out, o_busy, o_dropped}, 64'd0);
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        apply(64'h0, 12, r_ov, r_bv, r_dv);
        check("rst_gap_after_out",  r_ov, 64'h0);
        check("rst_gap_after_busy", r_bv, 64'h0);

        // Reset during HIGH with trigger held through release: one new pulse
        apply(64'h3, 2, r_ov, r_bv, r_dv);
        check("pre_rst_high_out", {63'd0, o_out}, 64'd1);
        #2;
        i_rst_n = 1'b0;
        #1;
        check("rst_high_async", {61'd0, o_out, o_busy, o_dropped}, 64'd0);
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        run_case("rst_release_held", 64'h3FF, 64'hF, 64'h7F, 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_pulse_stretcher
`default_nettype wire
